// File: rtl/demux4_buf.sv
// demux4_buf: steers one producer word to one of four consumer channels.
// Each channel owns a single-entry holding register with valid/ready
// handshaking, so a stalled consumer only blocks words addressed to it.
//
// Ports:
//   clk        system clock, rising edge
//   reset      asynchronous, active-high reset
//   d          input data word
//   s          destination channel select (0..3)
//   valid_in   producer has a word on d/s this cycle
//   ready_in   channel s can take a word this cycle
//   y0..y3     channel data, straight from the holding registers
//   valid_out  bit i set while channel i holds a word
//   ready_out  bit i set when consumer i takes y_i this cycle
//   busy       any channel holds a word
module demux4_buf #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  input  logic [1:0]       s,
  input  logic             valid_in,
  output logic             ready_in,
  output logic [WIDTH-1:0] y0,
  output logic [WIDTH-1:0] y1,
  output logic [WIDTH-1:0] y2,
  output logic [WIDTH-1:0] y3,
  output logic [3:0]       valid_out,
  input  logic [3:0]       ready_out,
  output logic             busy
);

  logic [3:0]       full;
  logic [WIDTH-1:0] data [4];
  logic             acc;

  // A full channel can still accept when its consumer drains in the same
  // cycle, which gives back-to-back transfers without a bubble.
  assign ready_in = ~full[s] | ready_out[s];
  assign acc      = valid_in & ready_in;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      full <= 4'b0000;
      for (int i = 0; i < 4; i++) begin
        data[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (acc && (s == 2'(i))) begin
          data[i] <= d;
          full[i] <= 1'b1;
        end else if (full[i] && ready_out[i]) begin
          full[i] <= 1'b0;
        end
      end
    end
  end

  assign valid_out = full;
  assign busy      = |full;
  assign y0        = data[0];
  assign y1        = data[1];
  assign y2        = data[2];
  assign y3        = data[3];

endmodule

// File: tb/tb_demux4_buf.sv
module tb_demux4_buf;

  logic       clk;
  logic       reset;
  logic [7:0] d;
  logic [1:0] s;
  logic       valid_in;
  logic       ready_in;
  logic [7:0] y0, y1, y2, y3;
  logic [3:0] valid_out;
  logic [3:0] ready_out;
  logic       busy;

  int errors = 0;
  int checks = 0;

  // Reference model: per-channel FIFO of words in flight (capacity one) and
  // the last word written into each channel, which is what y_i shows.
  logic [7:0] q [4][$];
  logic [7:0] last [4];
  int         accepts = 0;

  demux4_buf #(.WIDTH(8)) dut (
    .clk(clk), .reset(reset), .d(d), .s(s), .valid_in(valid_in),
    .ready_in(ready_in), .y0(y0), .y1(y1), .y2(y2), .y3(y3),
    .valid_out(valid_out), .ready_out(ready_out), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic model_ready(input logic [1:0] ss, input logic [3:0] ro);
    return (q[ss].size() == 0) || ro[ss];
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 4; i++) begin
      q[i].delete();
      last[i] = 8'h00;
    end
  endtask

  task automatic check_outputs(input string tag);
    logic [3:0] ev;
    for (int i = 0; i < 4; i++) ev[i] = (q[i].size() != 0);
    chk({tag, ".valid_out"}, 32'(valid_out), 32'(ev));
    chk({tag, ".busy"}, 32'(busy), 32'(ev != 4'b0000));
    chk({tag, ".y0"}, 32'(y0), 32'(last[0]));
    chk({tag, ".y1"}, 32'(y1), 32'(last[1]));
    chk({tag, ".y2"}, 32'(y2), 32'(last[2]));
    chk({tag, ".y3"}, 32'(y3), 32'(last[3]));
  endtask

  // Called at a negedge: drive inputs, check ready_in, clock once, advance
  // the model, and check the outputs at the following negedge.
  task automatic step(input string tag, input logic [7:0] dd, input logic [1:0] ss,
                      input logic vv, input logic [3:0] ro);
    logic er;
    d = dd; s = ss; valid_in = vv; ready_out = ro;
    #1;
    er = model_ready(ss, ro);
    chk({tag, ".ready_in"}, 32'(ready_in), 32'(er));
    @(posedge clk);
    for (int i = 0; i < 4; i++)
      if (ro[i] && q[i].size() != 0) void'(q[i].pop_front());
    if (vv && er) begin
      q[ss].push_back(dd);
      last[ss] = dd;
      accepts++;
    end
    @(negedge clk);
    check_outputs(tag);
  endtask

  initial begin
    reset = 1'b1; d = '0; s = '0; valid_in = 1'b0; ready_out = '0;
    model_clear();
    #2;
    check_outputs("reset_init");
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Basic routing
    step("route0", 8'hA0, 2'd0, 1'b1, 4'b0000);
    step("route1", 8'hA1, 2'd1, 1'b1, 4'b0000);
    step("route2", 8'hA2, 2'd2, 1'b1, 4'b0000);
    step("route3", 8'hA3, 2'd3, 1'b1, 4'b0000);
    chk("route.valid_all", 32'(valid_out), 32'h0000_000F);
    chk("route.y3_const", 32'(y3), 32'h0000_00A3);

    // Backpressure on channel 1 (holding A1)
    step("bp_stall", 8'h55, 2'd1, 1'b1, 4'b0000);
    chk("bp_stall.y1_const", 32'(y1), 32'h0000_00A1);
    step("bp_release", 8'h55, 2'd1, 1'b1, 4'b0010);
    chk("bp_release.y1_const", 32'(y1), 32'h0000_0055);

    // Empty everything, then stream 16 words into channel 3
    step("drain_all", 8'h00, 2'd0, 1'b0, 4'b1111);
    for (int k = 1; k <= 16; k++)
      step("stream", 8'(k), 2'd3, 1'b1, 4'b1111);
    step("stream_end", 8'h00, 2'd3, 1'b0, 4'b1111);

    // Isolation: channel 0 stalled full
    step("iso_fill0", 8'hC0, 2'd0, 1'b1, 4'b0000);
    step("iso_11", 8'h11, 2'd2, 1'b1, 4'b0100);
    step("iso_22", 8'h22, 2'd0, 1'b1, 4'b0100);
    chk("iso_22.y0_const", 32'(y0), 32'h0000_00C0);
    step("iso_33", 8'h33, 2'd2, 1'b1, 4'b0100);
    chk("iso_33.y2_const", 32'(y2), 32'h0000_0033);

    // Simultaneous drain on channel 1 and accept to channel 2
    step("sim_drain", 8'h00, 2'd0, 1'b0, 4'b1111);
    step("sim_fill1", 8'h31, 2'd1, 1'b1, 4'b0000);
    step("sim_both", 8'h7E, 2'd2, 1'b1, 4'b0010);
    chk("sim_both.valid_const", 32'(valid_out), 32'h0000_0004);

    // Asynchronous reset mid-cycle with channel 2 full
    #2;
    reset = 1'b1;
    #1;
    model_clear();
    check_outputs("async_reset");
    for (int k = 0; k < 4; k++) begin
      s = 2'(k); ready_out = 4'b0000; #1;
      chk("async_reset.ready_in", 32'(ready_in), 32'h1);
    end
    @(negedge clk);
    reset = 1'b0;

    // Randomized traffic; the producer holds d/s until accepted
    begin
      logic [7:0] rd;
      logic [1:0] rs;
      logic       pend;
      pend = 1'b0; rd = '0; rs = '0;
      for (int n = 0; n < 400; n++) begin
        logic vv;
        if (!pend) begin
          rd = 8'($urandom);
          rs = 2'($urandom_range(0, 3));
        end
        vv = pend || ($urandom_range(0, 3) != 0);
        pend = vv && !model_ready(rs, 4'b0000);
        begin
          logic [3:0] ro;
          ro = 4'($urandom);
          pend = vv && !model_ready(rs, ro);
          step("rand", rd, rs, vv, ro);
        end
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/demux4_buf.md
Name: demux4_buf

Overview:
- Inverse-direction companion to the 4:1 data selector: routes one input word to one of four destination channels chosen by a 2-bit select `s`.
- Each channel has a one-entry holding register and a valid/ready handshake, so a stalled destination blocks only traffic addressed to it.
- Used wherever one producer (e.g. writeback or load data) must be steered to one of four consumers.

Parameters:
- WIDTH, 8, data width of the input word and of each output channel.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- d  input  WIDTH  input data word.
- s  input  2  destination select: 0 → y0, 1 → y1, 2 → y2, 3 → y3.
- valid_in  input  1  producer asserts: d/s are valid this cycle.
- ready_in  output  1  block can accept d into channel s this cycle.
- y0, y1, y2, y3  output  WIDTH  channel data; each driven from that channel's holding register.
- valid_out  output  4  bit i high when channel i holds a word.
- ready_out  input  4  bit i high when consumer i takes y_i this cycle.
- busy  output  1  OR of valid_out.

Behaviour:
- State per channel i:
  - full[i], 1 bit.
  - data_i, WIDTH bits.
  - valid_out[i] = full[i].
  - y_i = data_i.
- Reset (asynchronous, whenever reset=1):
  - full = 4'b0000; data_0..3 = 0.
  - Therefore valid_out = 0, busy = 0, y0..y3 = 0.
  - Reset asserted mid-transfer discards all held words, with no output pulse.
- ready_in = ~full[s] | ready_out[s].
  - Combinational from s, full and ready_out.
  - Independent of valid_in and d.
- Accept: acc = valid_in & ready_in. Word goes to channel k = s.
- Drain: dr[i] = full[i] & ready_out[i].
- Per-channel next state on rising clk:
  - acc and i == k: data_i <= d; full[i] <= 1. This covers an empty channel, and a full channel drained in the same cycle (back-to-back, no bubble).
  - Otherwise, if dr[i]: full[i] <= 0; data_i holds its value.
  - Otherwise: hold.
- Latency and throughput:
  - Word accepted at edge N appears on y_k with valid_out[k]=1 in the cycle after edge N.
  - 1 word/cycle into any channel whose consumer keeps ready_out high.
- Backpressure:
  - Channel k full and ready_out[k]=0 → ready_in=0 for s=k.
  - The producer must hold d and s stable until accepted; d and s may change while valid_in=0.
- Independence: a stalled channel never blocks accepts to other channels; different channels may drain in the same cycle as an accept.
- Ordering: words to the same channel leave in acceptance order; there is no ordering guarantee across channels.
- Invariant: no word is dropped or duplicated. Each accept produces exactly one drain handshake on its channel unless reset intervenes.
- ready_out[i] while full[i]=0 has no effect.
- s is ignored when valid_in=0, except that ready_in is still computed from it.

Test Plan:
- Reset: assert reset asynchronously mid-cycle with channel 2 full → full, valid_out and busy go to 0 immediately (before the next edge), y2 = 0; ready_in = 1 for every s.
- Basic routing: ready_out = 4'b0000; send d = 8'hA0, A1, A2, A3 with s = 0, 1, 2, 3 on consecutive cycles → after the 4th edge valid_out = 4'b1111, y0..y3 = A0..A3, busy = 1.
- Backpressure: channel 1 full, ready_out[1] = 0, valid_in = 1, s = 1, d = 8'h55 → ready_in = 0, y1 unchanged. Raise ready_out[1] → same cycle ready_in = 1; next cycle y1 = 8'h55, valid_out[1] = 1.
- Streaming: ready_out = 4'b1111; stream 8'h01..8'h10 to s = 3 every cycle → ready_in stays 1, y3 shows each value one cycle after acceptance, 16 handshakes with no bubbles.
- Isolation: channel 0 stalled full (ready_out[0] = 0); alternate s = 2, 0, 2 with d = 8'h11, 22, 33 → the 8'h22 is held off (ready_in = 0 that cycle); y2 delivers 11 then 33; channel 0 content is unchanged.
- Simultaneous drain and accept on different channels: channel 1 drains while d = 8'h7E is accepted to s = 2 in the same cycle → next cycle valid_out = 4'b0100, y2 = 8'h7E.
